// File: rtl/la_ao32_filt_pkg.sv
// Shared constants for the la_ao32_filt deglitch filter slice.
// Holds only the legal parameter floors; decode and widths stay local to the filter.
package la_ao32_filt_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int DEPTH_MIN       = 1;

    function automatic int clamp_min(input int value, input int floor);
        return (value < floor) ? floor : value;
    endfunction

endpackage

// File: rtl/la_ao32_filt_if.sv
// Signal bundle between a raw asynchronous term source and the la_ao32_filt deglitcher.
// The master drives the enable and raw term; the slave returns the filtered level and pulses.
interface la_ao32_filt_if;

    logic en;
    logic in;
    logic out;
    logic rise;
    logic fall;
    logic busy;

    modport master (output en, output in, input out, input rise, input fall, input busy);
    modport slave  (input en, input in, output out, output rise, output fall, output busy);

endinterface

// File: rtl/la_ao32_filt_dsync.sv
// Plain flop-chain synchronizer: in is visible on out STAGES edges after it is sampled.
// Runs unconditionally so the filter always sees the current synchronized term.
module la_dsync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    logic [STAGES-1:0] sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], in};
        end
    end

    assign out = sync[STAGES-1];

endmodule

// File: rtl/la_ao32_filt.sv
// Synchronizing deglitch filter: accepts a new input level only after DEPTH enabled
// cycles of stability, and reports the filtered level with one-cycle rise/fall pulses.
module la_ao32_filt
    import la_ao32_filt_pkg::*;
#(
    parameter string PROP       = "DEFAULT",
    parameter int    SYNCSTAGES = 2,
    parameter int    DEPTH      = 4
) (
    input logic           clk,
    input logic           reset,
    la_ao32_filt_if.slave bus
);

    localparam int SYNC_N  = clamp_min(SYNCSTAGES, SYNC_STAGES_MIN);
    localparam int DEPTH_N = clamp_min(DEPTH, DEPTH_MIN);
    localparam int CW      = ($clog2(DEPTH_N) > 0) ? $clog2(DEPTH_N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH_N - 1);

    // PROP is a target hint carried for the implementation flow; no logic depends on it.
    if (PROP == "") begin : g_prop_empty
    end

    logic          in_s;
    logic [CW-1:0] cnt;
    logic          out_q;
    logic          rise_q;
    logic          fall_q;
    logic          qual;

    la_dsync #(
        .STAGES (SYNC_N)
    ) u_dsync (
        .clk   (clk),
        .reset (reset),
        .in    (bus.in),
        .out   (in_s)
    );

    // IDLE/QUAL is carried entirely by cnt; a nonzero count means a candidate is pending.
    assign qual = (cnt != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            out_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (bus.en) begin
                if (in_s == out_q) begin
                    cnt <= '0;
                end else if (cnt != CNT_LAST) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    out_q  <= in_s;
                    cnt    <= '0;
                    rise_q <= in_s;
                    fall_q <= ~in_s;
                end
            end
        end
    end

    assign bus.out  = out_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
    assign bus.busy = qual;

endmodule

// File: tb/tb_la_ao32_filt.sv
// Self-checking bench for la_ao32_filt: directed scenarios plus randomized traffic,
// checked against a run-length reference model of two differently sized instances.
module tb_la_ao32_filt;

    logic clk = 1'b0;
    logic reset;
    logic en_r;
    logic in_r;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    la_ao32_filt_if bus_a ();
    la_ao32_filt_if bus_b ();

    assign bus_a.en = en_r;
    assign bus_a.in = in_r;
    assign bus_b.en = en_r;
    assign bus_b.in = in_r;

    la_ao32_filt #(.PROP("DEFAULT"), .SYNCSTAGES(2), .DEPTH(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    la_ao32_filt #(.PROP("DEFAULT"), .SYNCSTAGES(3), .DEPTH(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    // Reference: history of raw samples, and a run length of enabled edges on which
    // the synchronized value disagreed with the accepted level.
    typedef struct {
        int         stages;
        int         depth;
        logic [7:0] hist;
        int         run;
        logic       out;
        logic       rise;
        logic       fall;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;

    function automatic mdl_t mdl_clear(input int stages, input int depth);
        mdl_t m;
        m.stages = stages;
        m.depth  = depth;
        m.hist   = '0;
        m.run    = 0;
        m.out    = 1'b0;
        m.rise   = 1'b0;
        m.fall   = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mdl_edge(input mdl_t m, input logic en, input logic in);
        mdl_t n;
        logic seen;
        n      = m;
        seen   = m.hist[m.stages-1];
        n.rise = 1'b0;
        n.fall = 1'b0;
        if (en) begin
            if (seen != m.out) begin
                n.run = m.run + 1;
                if (n.run >= m.depth) begin
                    n.out  = seen;
                    n.rise = seen;
                    n.fall = !seen;
                    n.run  = 0;
                end
            end else begin
                n.run = 0;
            end
        end
        n.hist = {m.hist[6:0], in};
        return n;
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("a.out",  bus_a.out,  ma.out);
        check("a.rise", bus_a.rise, ma.rise);
        check("a.fall", bus_a.fall, ma.fall);
        check("a.busy", bus_a.busy, ma.run != 0);
        check("b.out",  bus_b.out,  mb.out);
        check("b.rise", bus_b.rise, mb.rise);
        check("b.fall", bus_b.fall, mb.fall);
        check("b.busy", bus_b.busy, mb.run != 0);
        check("a.excl", bus_a.rise & bus_a.fall, 1'b0);
    endtask

    // One rising edge: advance the models with the inputs present at the edge, then sample.
    task automatic tick();
        @(posedge clk);
        ma = mdl_edge(ma, en_r, in_r);
        mb = mdl_edge(mb, en_r, in_r);
        #1;
        compare_model();
    endtask

    // Reset asserted between edges must clear everything before any further edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst.a.out",  bus_a.out,  1'b0);
        check("rst.a.rise", bus_a.rise, 1'b0);
        check("rst.a.fall", bus_a.fall, 1'b0);
        check("rst.a.busy", bus_a.busy, 1'b0);
        check("rst.b.out",  bus_b.out,  1'b0);
        check("rst.b.busy", bus_b.busy, 1'b0);
        ma = mdl_clear(2, 4);
        mb = mdl_clear(3, 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int nfall;
        en_r  = 1'b1;
        in_r  = 1'b1;
        reset = 1'b1;
        ma    = mdl_clear(2, 4);
        mb    = mdl_clear(3, 1);
        #2;

        // Release from reset with in=1; edge 0 is the first sampling edge.
        do_reset();
        for (int e = 0; e <= 7; e++) begin
            tick();
            check("d1.out",  bus_a.out,  e >= 5);
            check("d1.busy", bus_a.busy, (e >= 2) && (e <= 4));
            check("d1.rise", bus_a.rise, e == 5);
        end

        // Short dip of in while out=1 is a glitch: no fall, out holds.
        nfall = 0;
        in_r  = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick();
            nfall += int'(bus_a.fall);
        end
        in_r = 1'b1;
        for (int e = 0; e < 6; e++) begin
            tick();
            nfall += int'(bus_a.fall);
        end
        check("d2.nofall", nfall != 0, 1'b0);
        check("d2.out",    bus_a.out,  1'b1);
        check("d2.idle",   bus_a.busy, 1'b0);

        // Held low: out falls at edge k+5 with a single fall pulse.
        in_r = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            tick();
            check("d3.out",  bus_a.out,  e < 5);
            check("d3.fall", bus_a.fall, e == 5);
            check("d3.rise", bus_a.rise, 1'b0);
        end

        // Candidate at cnt=2 frozen by en=0, then completes two enabled edges later.
        in_r = 1'b1;
        for (int e = 0; e <= 3; e++) tick();
        check("d4.busy", bus_a.busy, 1'b1);
        en_r = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            check("d4.hold.busy", bus_a.busy, 1'b1);
            check("d4.hold.out",  bus_a.out,  1'b0);
        end
        en_r = 1'b1;
        tick();
        check("d4.out1", bus_a.out, 1'b0);
        tick();
        check("d4.out2",  bus_a.out,  1'b1);
        check("d4.rise2", bus_a.rise, 1'b1);

        // Candidate at cnt=3 discarded by an asynchronous reset.
        in_r = 1'b0;
        for (int e = 0; e <= 4; e++) tick();
        check("d5.busy", bus_a.busy, 1'b1);
        check("d5.out",  bus_a.out,  1'b1);
        do_reset();

        // DEPTH=1, SYNCSTAGES=3: a one-cycle pulse is reproduced three edges later.
        for (int e = 0; e < 4; e++) tick();
        in_r = 1'b1;
        tick();
        in_r = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("d6.out",  bus_b.out,  e == 3);
            check("d6.rise", bus_b.rise, e == 3);
            check("d6.fall", bus_b.fall, e == 4);
        end

        // Randomized traffic: sticky input levels, mostly-on enable, rare resets.
        for (int i = 0; i < 4000; i++) begin
            en_r = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) in_r = ~in_r;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
